// File: rtl/id_stage_if.sv
// Signal bundle between fetch/writeback/hazard control and the decode stage.
// The master drives the ID inputs and writeback; the slave (decode) drives the ID/EX outputs.
interface id_stage_if #(
    parameter int WIDTH = 32
);
    logic             id_valid;
    logic [WIDTH-1:0] id_pc;
    logic [WIDTH-1:0] id_instr;
    logic             stall;
    logic             flush;
    logic             hold;
    logic             wb_en;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;

    logic             ex_valid;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] ex_rs1_data;
    logic [WIDTH-1:0] ex_rs2_data;
    logic [WIDTH-1:0] ex_imm;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [3:0]       ex_alu_op;
    logic             ex_alu_src_imm;
    logic             ex_alu_src_pc;
    logic [2:0]       ex_funct3;
    logic             ex_reg_we;
    logic             ex_mem_re;
    logic             ex_mem_we;
    logic             ex_is_branch;
    logic             ex_is_jal;
    logic             ex_is_jalr;
    logic             ex_illegal;

    modport master (
        output id_valid, id_pc, id_instr, stall, flush, hold, wb_en, wb_rd, wb_data,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_alu_op, ex_alu_src_imm, ex_alu_src_pc, ex_funct3, ex_reg_we, ex_mem_re,
               ex_mem_we, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal
    );

    modport slave (
        input  id_valid, id_pc, id_instr, stall, flush, hold, wb_en, wb_rd, wb_data,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_alu_op, ex_alu_src_imm, ex_alu_src_pc, ex_funct3, ex_reg_we, ex_mem_re,
               ex_mem_we, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: 32x32 register file with write-through bypass, immediate
// generation, control decode and the ID/EX pipeline register.
package all_pkgs;
    localparam int WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] rs1_data;
        logic [WIDTH-1:0] rs2_data;
        logic [WIDTH-1:0] imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        alu_op_e          alu_op;
        logic             src_imm;
        logic             src_pc;
        logic [2:0]       funct3;
        logic             reg_we;
        logic             mem_re;
        logic             mem_we;
        logic             is_branch;
        logic             is_jal;
        logic             is_jalr;
        logic             illegal;
    } idex_t;
endpackage

module id_stage
    import all_pkgs::*;
#(
    parameter int NREGS = 32
) (
    input logic       clk,
    input logic       rst,
    id_stage_if.slave bus
);
    logic [WIDTH-1:0] r_regs [NREGS];
    idex_t            r_ex;

    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    opcode_e          w_opcode;
    logic [WIDTH-1:0] w_rs1_data;
    logic [WIDTH-1:0] w_rs2_data;
    logic [WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    idex_t            w_dec;

    assign w_rs1    = bus.id_instr[19:15];
    assign w_rs2    = bus.id_instr[24:20];
    assign w_funct3 = bus.id_instr[14:12];
    assign w_funct7 = bus.id_instr[31:25];
    assign w_opcode = opcode_e'(bus.id_instr[6:0]);

    // NOTE: the array itself is cleared on reset, so it has to stay in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
            r_regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // A writeback in the same cycle wins over the stored value.
    assign w_rs1_data = (w_rs1 == 5'd0) ? '0 :
                        (bus.wb_en && bus.wb_rd == w_rs1) ? bus.wb_data : r_regs[w_rs1];
    assign w_rs2_data = (w_rs2 == 5'd0) ? '0 :
                        (bus.wb_en && bus.wb_rd == w_rs2) ? bus.wb_data : r_regs[w_rs2];

    assign w_imm_i = {{20{bus.id_instr[31]}}, bus.id_instr[31:20]};
    assign w_imm_s = {{20{bus.id_instr[31]}}, bus.id_instr[31:25], bus.id_instr[11:7]};
    assign w_imm_b = {{19{bus.id_instr[31]}}, bus.id_instr[31], bus.id_instr[7],
                      bus.id_instr[30:25], bus.id_instr[11:8], 1'b0};
    assign w_imm_u = {bus.id_instr[31:12], 12'b0};
    assign w_imm_j = {{11{bus.id_instr[31]}}, bus.id_instr[31], bus.id_instr[19:12],
                      bus.id_instr[20], bus.id_instr[30:21], 1'b0};

    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: clearing the whole struct first keeps every field assigned on every path, so no latches.
    always_comb begin
        w_dec          = '0;
        w_dec.valid    = 1'b1;
        w_dec.pc       = bus.id_pc;
        w_dec.rs1      = w_rs1;
        w_dec.rs2      = w_rs2;
        w_dec.rd       = bus.id_instr[11:7];
        w_dec.rs1_data = w_rs1_data;
        w_dec.rs2_data = w_rs2_data;
        w_dec.funct3   = w_funct3;
        case (w_opcode)
            OPC_LUI: begin
                w_dec.alu_op  = ALU_PASS_B;
                w_dec.src_imm = 1'b1;
                w_dec.reg_we  = 1'b1;
                w_dec.imm     = w_imm_u;
            end
            OPC_AUIPC: begin
                w_dec.src_pc  = 1'b1;
                w_dec.src_imm = 1'b1;
                w_dec.reg_we  = 1'b1;
                w_dec.imm     = w_imm_u;
            end
            OPC_JAL: begin
                w_dec.src_pc  = 1'b1;
                w_dec.src_imm = 1'b1;
                w_dec.reg_we  = 1'b1;
                w_dec.is_jal  = 1'b1;
                w_dec.imm     = w_imm_j;
            end
            OPC_JALR: begin
                w_dec.src_imm = 1'b1;
                w_dec.reg_we  = 1'b1;
                w_dec.is_jalr = 1'b1;
                w_dec.imm     = w_imm_i;
            end
            OPC_BRANCH: begin
                if (w_funct3 inside {3'd2, 3'd3}) begin
                    w_dec.illegal = 1'b1;
                end else begin
                    w_dec.src_pc    = 1'b1;
                    w_dec.src_imm   = 1'b1;
                    w_dec.is_branch = 1'b1;
                    w_dec.imm       = w_imm_b;
                end
            end
            OPC_LOAD: begin
                if (w_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                    w_dec.src_imm = 1'b1;
                    w_dec.reg_we  = 1'b1;
                    w_dec.mem_re  = 1'b1;
                    w_dec.imm     = w_imm_i;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                if (w_funct3 <= 3'd2) begin
                    w_dec.src_imm = 1'b1;
                    w_dec.mem_we  = 1'b1;
                    w_dec.imm     = w_imm_s;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // Shift-immediates reuse imm[11:5] as funct7.
                if ((w_funct3 == 3'd1 && w_funct7 != 7'h00) ||
                    (w_funct3 == 3'd5 && w_funct7 != 7'h00 && w_funct7 != 7'h20)) begin
                    w_dec.illegal = 1'b1;
                end else begin
                    w_dec.alu_op  = alu_from_funct3(w_funct3, (w_funct3 == 3'd5) && bus.id_instr[30]);
                    w_dec.src_imm = 1'b1;
                    w_dec.reg_we  = 1'b1;
                    w_dec.imm     = w_imm_i;
                end
            end
            OPC_OP: begin
                if (w_funct7 == 7'h00 || (w_funct7 == 7'h20 && (w_funct3 == 3'd0 || w_funct3 == 3'd5))) begin
                    w_dec.alu_op = alu_from_funct3(w_funct3, bus.id_instr[30]);
                    w_dec.reg_we = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: w_dec.illegal = 1'b1;
        endcase
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_ex <= '0;
        end else if (bus.hold) begin
            r_ex <= r_ex;
        end else if (bus.stall || !bus.id_valid) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_dec;
        end
    end

    assign bus.ex_valid       = r_ex.valid;
    assign bus.ex_pc          = r_ex.pc;
    assign bus.ex_rs1_data    = r_ex.rs1_data;
    assign bus.ex_rs2_data    = r_ex.rs2_data;
    assign bus.ex_imm         = r_ex.imm;
    assign bus.ex_rs1         = r_ex.rs1;
    assign bus.ex_rs2         = r_ex.rs2;
    assign bus.ex_rd          = r_ex.rd;
    assign bus.ex_alu_op      = r_ex.alu_op;
    assign bus.ex_alu_src_imm = r_ex.src_imm;
    assign bus.ex_alu_src_pc  = r_ex.src_pc;
    assign bus.ex_funct3      = r_ex.funct3;
    assign bus.ex_reg_we      = r_ex.reg_we;
    assign bus.ex_mem_re      = r_ex.mem_re;
    assign bus.ex_mem_we      = r_ex.mem_we;
    assign bus.ex_is_branch   = r_ex.is_branch;
    assign bus.ex_is_jal      = r_ex.is_jal;
    assign bus.ex_is_jalr     = r_ex.is_jalr;
    assign bus.ex_illegal     = r_ex.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed cases with literal expectations, then randomized
// traffic compared each cycle against an instruction-level reference model.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        src_imm, src_pc;
        logic [2:0]  funct3;
        logic        reg_we, mem_re, mem_we, is_branch, is_jal, is_jalr, illegal;
    } exp_t;

    logic [31:0] m_regs [32];
    exp_t        m_ex;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
        return m_regs[idx];
    endfunction

    // ALU code per funct3; the "alternate" forms (SUB, SRA) sit one above their base op.
    function automatic logic [3:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'd0;  3'd1: return 4'd2;  3'd2: return 4'd3;  3'd3: return 4'd4;
            3'd4: return 4'd5;  3'd5: return 4'd6;  3'd6: return 4'd8;  default: return 4'd9;
        endcase
    endfunction

    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic        legal;
        byte         fmt;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] sgn;
        e = '0;
        e.valid = 1'b1;  e.pc = pc;
        e.rs1 = ins[19:15];  e.rs2 = ins[24:20];  e.rd = ins[11:7];
        e.rs1_data = m_read(ins[19:15]);  e.rs2_data = m_read(ins[24:20]);
        f3 = ins[14:12];  f7 = ins[31:25];  e.funct3 = f3;
        legal = 1'b1;  fmt = "R";
        case (ins[6:0])
            7'h37: begin fmt = "U"; e.alu = 4'd10; e.src_imm = 1; e.reg_we = 1; end
            7'h17: begin fmt = "U"; e.src_pc = 1; e.src_imm = 1; e.reg_we = 1; end
            7'h6F: begin fmt = "J"; e.src_pc = 1; e.src_imm = 1; e.reg_we = 1; e.is_jal = 1; end
            7'h67: begin fmt = "I"; e.src_imm = 1; e.reg_we = 1; e.is_jalr = 1; end
            7'h63: begin fmt = "B"; legal = (f3 != 2 && f3 != 3); e.src_pc = 1; e.src_imm = 1; e.is_branch = 1; end
            7'h03: begin fmt = "I"; legal = (f3 != 3 && f3 < 6); e.src_imm = 1; e.reg_we = 1; e.mem_re = 1; end
            7'h23: begin fmt = "S"; legal = (f3 <= 2); e.src_imm = 1; e.mem_we = 1; end
            7'h13: begin
                fmt = "I";
                if (f3 == 1) legal = (f7 == 0);
                if (f3 == 5) legal = (f7 == 0 || f7 == 7'h20);
                e.alu = alu_base(f3) + ((f3 == 5 && f7 == 7'h20) ? 4'd1 : 4'd0);
                e.src_imm = 1; e.reg_we = 1;
            end
            7'h33: begin
                legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                e.alu = alu_base(f3) + ((f7 == 7'h20) ? 4'd1 : 4'd0);
                e.reg_we = 1;
            end
            default: legal = 1'b0;
        endcase
        sgn = 32'($signed(ins) >>> 31);
        case (fmt)
            "I": e.imm = 32'($signed(ins) >>> 20);
            "S": e.imm = (sgn << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
            "B": e.imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            "U": e.imm = ins & 32'hFFFF_F000;
            "J": e.imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            default: e.imm = 32'd0;
        endcase
        if (!legal) begin
            e.alu = 0; e.src_imm = 0; e.src_pc = 0; e.imm = 0;
            e.reg_we = 0; e.mem_re = 0; e.mem_we = 0;
            e.is_branch = 0; e.is_jal = 0; e.is_jalr = 0;
            e.illegal = 1;
        end
        return e;
    endfunction

    task automatic compare_all();
        check("ex_valid",    32'(bus.ex_valid),       32'(m_ex.valid));
        check("ex_pc",       bus.ex_pc,               m_ex.pc);
        check("ex_rs1_data", bus.ex_rs1_data,         m_ex.rs1_data);
        check("ex_rs2_data", bus.ex_rs2_data,         m_ex.rs2_data);
        check("ex_imm",      bus.ex_imm,              m_ex.imm);
        check("ex_rs1",      32'(bus.ex_rs1),         32'(m_ex.rs1));
        check("ex_rs2",      32'(bus.ex_rs2),         32'(m_ex.rs2));
        check("ex_rd",       32'(bus.ex_rd),          32'(m_ex.rd));
        check("ex_alu_op",   32'(bus.ex_alu_op),      32'(m_ex.alu));
        check("ex_src_imm",  32'(bus.ex_alu_src_imm), 32'(m_ex.src_imm));
        check("ex_src_pc",   32'(bus.ex_alu_src_pc),  32'(m_ex.src_pc));
        check("ex_funct3",   32'(bus.ex_funct3),      32'(m_ex.funct3));
        check("ex_reg_we",   32'(bus.ex_reg_we),      32'(m_ex.reg_we));
        check("ex_mem_re",   32'(bus.ex_mem_re),      32'(m_ex.mem_re));
        check("ex_mem_we",   32'(bus.ex_mem_we),      32'(m_ex.mem_we));
        check("ex_is_branch", 32'(bus.ex_is_branch),  32'(m_ex.is_branch));
        check("ex_is_jal",   32'(bus.ex_is_jal),      32'(m_ex.is_jal));
        check("ex_is_jalr",  32'(bus.ex_is_jalr),     32'(m_ex.is_jalr));
        check("ex_illegal",  32'(bus.ex_illegal),     32'(m_ex.illegal));
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic st, input logic fl, input logic ho,
                         input logic we, input logic [4:0] rd, input logic [31:0] d);
        bus.id_valid = v;   bus.id_pc = pc;   bus.id_instr = ins;
        bus.stall = st;     bus.flush = fl;   bus.hold = ho;
        bus.wb_en = we;     bus.wb_rd = rd;   bus.wb_data = d;
    endtask

    // One clock: predict from pre-edge inputs, advance the model, compare after the edge.
    task automatic step();
        exp_t nxt;
        if (rst || bus.flush)                nxt = '0;
        else if (bus.hold)                   nxt = m_ex;
        else if (bus.stall || !bus.id_valid) nxt = '0;
        else                                 nxt = model_decode(bus.id_instr, bus.id_pc);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
            m_regs[bus.wb_rd] = bus.wb_data;
        end
        m_ex = nxt;
        compare_all();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 10);
        case (sel)
            0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;  8: w[6:0] = 7'h33;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 2) != 0) begin
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
        end
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_ex = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        check("reset ex_valid", 32'(bus.ex_valid), 32'd0);
        check("reset ex_pc", bus.ex_pc, 32'd0);
        rst = 1'b0;

        // addi x1,x0,5
        drive(1, 32'h100, 32'h0050_0093, 0, 0, 0, 0, 0, 0);
        step();
        check("addi rd", 32'(bus.ex_rd), 32'd1);
        check("addi imm", bus.ex_imm, 32'd5);
        check("addi alu", 32'(bus.ex_alu_op), 32'd0);
        check("addi src_imm", 32'(bus.ex_alu_src_imm), 32'd1);
        check("addi reg_we", 32'(bus.ex_reg_we), 32'd1);

        // beq x1,x2,-8
        drive(1, 32'h104, 32'hFE20_8CE3, 0, 0, 0, 0, 0, 0);
        step();
        check("beq imm", bus.ex_imm, 32'hFFFF_FFF8);
        check("beq is_branch", 32'(bus.ex_is_branch), 32'd1);
        check("beq reg_we", 32'(bus.ex_reg_we), 32'd0);

        // lui x5,0x12345
        drive(1, 32'h108, 32'h1234_52B7, 0, 0, 0, 0, 0, 0);
        step();
        check("lui imm", bus.ex_imm, 32'h1234_5000);
        check("lui alu", 32'(bus.ex_alu_op), 32'd10);

        // add x4,x3,x0 with a same-cycle writeback of x3
        drive(1, 32'h10C, 32'h0001_8233, 0, 0, 0, 1, 5'd3, 32'hDEAD_BEEF);
        step();
        check("bypass rs1_data", bus.ex_rs1_data, 32'hDEAD_BEEF);
        check("bypass rs2_data", bus.ex_rs2_data, 32'd0);

        // writes to x0 are discarded, both same-cycle and afterwards
        drive(1, 32'h110, 32'h0000_0093, 0, 0, 0, 1, 5'd0, 32'h55);
        step();
        check("x0 bypass", bus.ex_rs1_data, 32'd0);
        drive(1, 32'h114, 32'h0000_0093, 0, 0, 0, 0, 0, 0);
        step();
        check("x0 array", bus.ex_rs1_data, 32'd0);

        // hold freezes ID/EX for three edges while the array keeps updating
        drive(1, 32'h200, 32'h0050_0093, 0, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h204 + 32'(k), 32'hFFFF_FFFF, 0, 0, 1, 1, 5'd9, 32'hAA + 32'(k));
            step();
            check("hold ex_pc", bus.ex_pc, 32'h200);
            check("hold ex_imm", bus.ex_imm, 32'd5);
            check("hold ex_valid", 32'(bus.ex_valid), 32'd1);
        end

        // flush beats hold
        drive(1, 32'h208, 32'h0050_0093, 0, 1, 1, 0, 0, 0);
        step();
        check("flush+hold ex_valid", 32'(bus.ex_valid), 32'd0);

        drive(1, 32'h20C, 32'h0050_0093, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 32'h210, 32'h0050_0093, 1, 0, 0, 0, 0, 0);
        step();
        check("stall ex_valid", 32'(bus.ex_valid), 32'd0);
        check("stall reg_we", 32'(bus.ex_reg_we), 32'd0);

        drive(1, 32'h300, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
        step();
        check("ill1 illegal", 32'(bus.ex_illegal), 32'd1);
        check("ill1 valid", 32'(bus.ex_valid), 32'd1);
        check("ill1 enables", {29'd0, bus.ex_reg_we, bus.ex_mem_re, bus.ex_mem_we}, 32'd0);
        drive(1, 32'h304, 32'h4000_1033, 0, 0, 0, 0, 0, 0);
        step();
        check("ill2 illegal", 32'(bus.ex_illegal), 32'd1);
        check("ill2 valid", 32'(bus.ex_valid), 32'd1);
        check("ill2 enables", {29'd0, bus.ex_reg_we, bus.ex_mem_re, bus.ex_mem_we}, 32'd0);

        // x7 written, visible through the array, then wiped by reset
        drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h1234);
        step();
        drive(1, 32'h400, 32'h0003_8093, 0, 0, 0, 0, 0, 0);
        step();
        check("x7 before reset", bus.ex_rs1_data, 32'h1234);
        rst = 1'b1;
        step();
        check("mid reset ex_valid", 32'(bus.ex_valid), 32'd0);
        rst = 1'b0;
        step();
        check("x7 after reset", bus.ex_rs1_data, 32'd0);
        check("after reset valid", 32'(bus.ex_valid), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 99) < 85, $urandom, rand_instr(),
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 1) != 0,
                  ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom),
                  $urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
